// File: rtl/odd_pkg.sv
// Shared definitions for the odd-side issue stage.
//   - Forward-select codes driven onto ForwardA/B/C.
//   - Unit-class codes held in CSO[0:1].
//   - tag_t: {we, addr} as carried by the odd pipe's in-flight stage tags.
//   - issue_state_e: the three states of the single-entry hold register.
package odd_pkg;

   localparam int NSTAGE = 7;

   localparam logic [3:0] FWD_NONE = 4'b0000;
   localparam logic [3:0] FWD_S5   = 4'b0010;
   localparam logic [3:0] FWD_S6   = 4'b0011;
   localparam logic [3:0] FWD_S7   = 4'b0100;
   localparam logic [3:0] FWD_PERM = 4'b0101;
   localparam logic [3:0] FWD_LS   = 4'b0110;
   localparam logic [3:0] FWD_BR   = 4'b0111;

   localparam logic [1:0] UC_LNOP = 2'b00;
   localparam logic [1:0] UC_PERM = 2'b01;
   localparam logic [1:0] UC_BR   = 2'b10;
   localparam logic [1:0] UC_LS   = 2'b11;

   typedef struct packed {
      logic       we;
      logic [0:6] addr;
   } tag_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HELD  = 2'd1,
      ST_STALL = 2'd2
   } issue_state_e;

   // Unit class lives in the two leading (MSB-first) bits of the opcode class.
   function automatic logic [1:0] unit_class(input logic [0:5] cso);
      return cso[0:1];
   endfunction

endpackage

// File: rtl/odd_hazard_check.sv
// RAW hazard / forward-select evaluation for one source operand.
//   src       : source register address
//   src_used  : operand is actually read (already masked for LNOP)
//   tags      : {we, addr} of odd pipe stages 1..7
//   csos      : opcode class of odd pipe stages 1..7
//   hazard    : operand cannot be obtained this cycle
//   fwd       : forward-select code for this operand
module odd_hazard_check
   import odd_pkg::*;
(
   input  logic [0:6] src,
   input  logic       src_used,
   input  tag_t       tags [1:NSTAGE],
   input  logic [0:5] csos [1:NSTAGE],
   output logic       hazard,
   output logic [3:0] fwd
);

   logic [2:0] hit_k;
   logic [1:0] hit_cls;

   always_comb begin
      hit_k   = 3'd0;
      hit_cls = UC_LNOP;
      // Scan oldest to youngest so the youngest producer overwrites older hits.
      for (int k = NSTAGE; k >= 1; k--) begin
         if (tags[k].we && (tags[k].addr == src)) begin
            hit_k   = 3'(k);
            hit_cls = unit_class(csos[k]);
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
      fwd    = FWD_NONE;
      if (src_used) begin
         case (hit_k)
            3'd1, 3'd2, 3'd3, 3'd4: hazard = 1'b1;
            // Load/store results only appear at stage 7.
            3'd5: begin
               hazard = (hit_cls == UC_LS);
               fwd    = FWD_S5;
            end
            3'd6: begin
               hazard = (hit_cls == UC_LS);
               fwd    = FWD_S6;
            end
            3'd7:    fwd = FWD_S7;
            default: fwd = FWD_NONE;
         endcase
      end
   end

endmodule

// File: rtl/odd_issue_stage.sv
// Issue / operand-fetch stage in front of the odd pipe.
// Holds one decoded odd-slot instruction, reads its three operands from the
// 128-entry register file (with write-through from the odd write-back port),
// checks the odd pipe's in-flight tags for RAW hazards and either issues the
// instruction combinationally or stalls, presenting an LNOP downstream.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   InValid / InReady         : upstream handshake (InReady is combinational)
//   CSOInst, RA, RB, RC,
//   SrcUse, RT, PCInst        : decoded instruction fields
//   Flush                     : discard the held instruction
//   TagO1..7, CSO1..7         : odd pipe in-flight tags and opcode classes
//   WBData, WBAddr, WBEn      : odd pipe write-back into the register file
//   Input1..3                 : operands A/B/C to the odd pipe
//   CSOOut, AddrOut, PCOut    : opcode class, destination, PC to the odd pipe
//   ForwardA/B/C              : forward selects per operand
//   Stalled, StallCount       : hazard stall flag and saturating counter
module odd_issue_stage
   import odd_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int REGS  = 128,
   parameter int CNTW  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [0:5]       CSOInst,
   input  logic [0:6]       RA,
   input  logic [0:6]       RB,
   input  logic [0:6]       RC,
   input  logic [2:0]       SrcUse,
   input  logic [0:6]       RT,
   input  logic [31:0]      PCInst,
   input  logic             Flush,
   input  logic [0:7]       TagO1,
   input  logic [0:7]       TagO2,
   input  logic [0:7]       TagO3,
   input  logic [0:7]       TagO4,
   input  logic [0:7]       TagO5,
   input  logic [0:7]       TagO6,
   input  logic [0:7]       TagO7,
   input  logic [0:5]       CSO1,
   input  logic [0:5]       CSO2,
   input  logic [0:5]       CSO3,
   input  logic [0:5]       CSO4,
   input  logic [0:5]       CSO5,
   input  logic [0:5]       CSO6,
   input  logic [0:5]       CSO7,
   input  logic [WIDTH-1:0] WBData,
   input  logic [0:6]       WBAddr,
   input  logic             WBEn,
   output logic [WIDTH-1:0] Input1,
   output logic [WIDTH-1:0] Input2,
   output logic [WIDTH-1:0] Input3,
   output logic [0:5]       CSOOut,
   output logic [0:6]       AddrOut,
   output logic [31:0]      PCOut,
   output logic [3:0]       ForwardA,
   output logic [3:0]       ForwardB,
   output logic [3:0]       ForwardC,
   output logic             Stalled,
   output logic [CNTW-1:0]  StallCount
);

   // Hold register
   logic             hr_v_q,   hr_v_d;
   logic [0:5]       hr_cso_q, hr_cso_d;
   logic [0:6]       hr_ra_q,  hr_ra_d;
   logic [0:6]       hr_rb_q,  hr_rb_d;
   logic [0:6]       hr_rc_q,  hr_rc_d;
   logic [2:0]       hr_use_q, hr_use_d;
   logic [0:6]       hr_rt_q,  hr_rt_d;
   logic [31:0]      hr_pc_q,  hr_pc_d;
   logic [CNTW-1:0]  cnt_q,    cnt_d;

   logic [WIDTH-1:0] rf_q [REGS];

   tag_t             tags [1:NSTAGE];
   logic [0:5]       csos [1:NSTAGE];

   logic             hr_lnop;
   logic             haz_a, haz_b, haz_c, hazard_any;
   logic [3:0]       fwd_a, fwd_b, fwd_c;
   logic [WIDTH-1:0] rd_a, rd_b, rd_c;
   issue_state_e     state;
   logic             issue, stall_now, capture;

   always_comb begin
      tags[1] = TagO1;  tags[2] = TagO2;  tags[3] = TagO3;  tags[4] = TagO4;
      tags[5] = TagO5;  tags[6] = TagO6;  tags[7] = TagO7;
      csos[1] = CSO1;   csos[2] = CSO2;   csos[3] = CSO3;   csos[4] = CSO4;
      csos[5] = CSO5;   csos[6] = CSO6;   csos[7] = CSO7;
   end

   // An LNOP reads nothing, so it never hazards and carries no forwards.
   assign hr_lnop = (unit_class(hr_cso_q) == UC_LNOP);

   odd_hazard_check u_haz_a (
      .src      (hr_ra_q),
      .src_used (hr_use_q[0] && !hr_lnop),
      .tags     (tags),
      .csos     (csos),
      .hazard   (haz_a),
      .fwd      (fwd_a)
   );

   odd_hazard_check u_haz_b (
      .src      (hr_rb_q),
      .src_used (hr_use_q[1] && !hr_lnop),
      .tags     (tags),
      .csos     (csos),
      .hazard   (haz_b),
      .fwd      (fwd_b)
   );

   odd_hazard_check u_haz_c (
      .src      (hr_rc_q),
      .src_used (hr_use_q[2] && !hr_lnop),
      .tags     (tags),
      .csos     (csos),
      .hazard   (haz_c),
      .fwd      (fwd_c)
   );

   assign hazard_any = haz_a || haz_b || haz_c;

   // Register-file read with write-through from the same-cycle write-back.
   always_comb begin
      rd_a = (WBEn && (WBAddr == hr_ra_q)) ? WBData : rf_q[hr_ra_q];
      rd_b = (WBEn && (WBAddr == hr_rb_q)) ? WBData : rf_q[hr_rb_q];
      rd_c = (WBEn && (WBAddr == hr_rc_q)) ? WBData : rf_q[hr_rc_q];
   end

   // State decode
   always_comb begin
      state = ST_EMPTY;
      if (hr_v_q) begin
         state = hazard_any ? ST_STALL : ST_HELD;
      end
   end

   // Next-state logic
   always_comb begin
      InReady   = (state != ST_STALL);
      issue     = (state == ST_HELD) && !Flush;
      stall_now = (state == ST_STALL) && !Flush;
      capture   = InValid && InReady && !Flush;

      hr_cso_d  = hr_cso_q;
      hr_ra_d   = hr_ra_q;
      hr_rb_d   = hr_rb_q;
      hr_rc_d   = hr_rc_q;
      hr_use_d  = hr_use_q;
      hr_rt_d   = hr_rt_q;
      hr_pc_d   = hr_pc_q;

      // A capture in an issue cycle simply replaces the issuing entry.
      if (capture) begin
         hr_cso_d = CSOInst;
         hr_ra_d  = RA;
         hr_rb_d  = RB;
         hr_rc_d  = RC;
         hr_use_d = SrcUse;
         hr_rt_d  = RT;
         hr_pc_d  = PCInst;
      end

      if (Flush) begin
         hr_v_d = 1'b0;
      end else if (capture) begin
         hr_v_d = 1'b1;
      end else if (issue) begin
         hr_v_d = 1'b0;
      end else begin
         hr_v_d = hr_v_q;
      end

      cnt_d = cnt_q;
      if (stall_now && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Outputs: everything is zero (LNOP, no forwards) unless issuing.
   always_comb begin
      Input1     = '0;
      Input2     = '0;
      Input3     = '0;
      CSOOut     = '0;
      AddrOut    = '0;
      PCOut      = '0;
      ForwardA   = FWD_NONE;
      ForwardB   = FWD_NONE;
      ForwardC   = FWD_NONE;
      Stalled    = stall_now;
      StallCount = cnt_q;
      if (issue) begin
         Input1   = rd_a;
         Input2   = rd_b;
         Input3   = rd_c;
         CSOOut   = hr_cso_q;
         AddrOut  = hr_rt_q;
         PCOut    = hr_pc_q;
         ForwardA = fwd_a;
         ForwardB = fwd_b;
         ForwardC = fwd_c;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         hr_v_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hr_v_q <= hr_v_d;
         cnt_q  <= cnt_d;
      end
      hr_cso_q <= hr_cso_d;
      hr_ra_q  <= hr_ra_d;
      hr_rb_q  <= hr_rb_d;
      hr_rc_q  <= hr_rc_d;
      hr_use_q <= hr_use_d;
      hr_rt_q  <= hr_rt_d;
      hr_pc_q  <= hr_pc_d;
   end

   // Register file contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (WBEn) begin
         rf_q[WBAddr] <= WBData;
      end
   end

endmodule

// File: tb/tb_odd_issue_stage.sv
module tb_odd_issue_stage;

   localparam int W = 128;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          InValid;
   logic          InReady;
   logic [5:0]    CSOInst;
   logic [6:0]    RA, RB, RC, RT;
   logic [2:0]    SrcUse;
   logic [31:0]   PCInst;
   logic          Flush;
   logic [7:0]    tg [1:7];
   logic [5:0]    cs [1:7];
   logic [W-1:0]  WBData;
   logic [6:0]    WBAddr;
   logic          WBEn;
   logic [W-1:0]  Input1, Input2, Input3;
   logic [5:0]    CSOOut;
   logic [6:0]    AddrOut;
   logic [31:0]   PCOut;
   logic [3:0]    ForwardA, ForwardB, ForwardC;
   logic          Stalled;
   logic [CW-1:0] StallCount;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   logic [W-1:0] m_rf [128];
   logic         m_v;
   logic [5:0]   m_cso;
   logic [6:0]   m_src [3];
   logic [2:0]   m_use;
   logic [6:0]   m_rt;
   logic [31:0]  m_pc;
   int           m_cnt;
   logic         e_ready, e_cap;

   odd_issue_stage #(.WIDTH(W), .REGS(128), .CNTW(CW)) dut (
      .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
      .CSOInst(CSOInst), .RA(RA), .RB(RB), .RC(RC), .SrcUse(SrcUse), .RT(RT),
      .PCInst(PCInst), .Flush(Flush),
      .TagO1(tg[1]), .TagO2(tg[2]), .TagO3(tg[3]), .TagO4(tg[4]),
      .TagO5(tg[5]), .TagO6(tg[6]), .TagO7(tg[7]),
      .CSO1(cs[1]), .CSO2(cs[2]), .CSO3(cs[3]), .CSO4(cs[4]),
      .CSO5(cs[5]), .CSO6(cs[6]), .CSO7(cs[7]),
      .WBData(WBData), .WBAddr(WBAddr), .WBEn(WBEn),
      .Input1(Input1), .Input2(Input2), .Input3(Input3),
      .CSOOut(CSOOut), .AddrOut(AddrOut), .PCOut(PCOut),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .ForwardC(ForwardC),
      .Stalled(Stalled), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Youngest in-flight stage writing address a, 0 when none.
   function automatic int youngest(input logic [6:0] a);
      for (int k = 1; k <= 7; k++)
         if (tg[k][7] && tg[k][6:0] == a) return k;
      return 0;
   endfunction

   task automatic idle();
      InValid = 0; CSOInst = 0; RA = 0; RB = 0; RC = 0; RT = 0; SrcUse = 0;
      PCInst = 0; Flush = 0; WBEn = 0; WBAddr = 0; WBData = 0; reset = 0;
      for (int k = 1; k <= 7; k++) begin tg[k] = 0; cs[k] = 0; end
   endtask

   task automatic inst(input logic [5:0] c, input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] d, input logic [2:0] u, input logic [6:0] t,
                       input logic [31:0] pc);
      InValid = 1; CSOInst = c; RA = a; RB = b; RC = d; SrcUse = u; RT = t; PCInst = pc;
   endtask

   // Compare every output against the model, mid-cycle.
   task automatic check_phase();
      logic         any_h, issue, stl;
      logic [3:0]   fw [3];
      logic [W-1:0] val [3];
      #2;
      any_h = 0;
      for (int s = 0; s < 3; s++) begin
         int k;
         fw[s] = 0;
         val[s] = (WBEn && WBAddr == m_src[s]) ? WBData : m_rf[m_src[s]];
         k = youngest(m_src[s]);
         if (m_use[s] && m_cso[5:4] != 2'b00 && k != 0) begin
            if (k <= 4 || (k <= 6 && cs[k][5:4] == 2'b11)) any_h = 1;
            if (k >= 5) fw[s] = 4'(k - 3);
         end
      end
      e_ready = !(m_v && any_h);
      issue   = m_v && !any_h && !Flush;
      stl     = m_v && any_h && !Flush;
      e_cap   = InValid && e_ready && !Flush;
      chk("InReady", InReady, e_ready);
      chk("Stalled", Stalled, stl);
      chk("StallCount", StallCount, m_cnt);
      chk("CSOOut", CSOOut, issue ? m_cso : 6'd0);
      chk("AddrOut", AddrOut, issue ? m_rt : 7'd0);
      chk("PCOut", PCOut, issue ? m_pc : 32'd0);
      chk("Input1", Input1, issue ? val[0] : '0);
      chk("Input2", Input2, issue ? val[1] : '0);
      chk("Input3", Input3, issue ? val[2] : '0);
      chk("ForwardA", ForwardA, issue ? fw[0] : 4'd0);
      chk("ForwardB", ForwardB, issue ? fw[1] : 4'd0);
      chk("ForwardC", ForwardC, issue ? fw[2] : 4'd0);
      // Next-state of the model
      if (e_cap) begin
         m_cso = CSOInst; m_src[0] = RA; m_src[1] = RB; m_src[2] = RC;
         m_use = SrcUse; m_rt = RT; m_pc = PCInst;
      end
      if (reset) begin
         m_v = 0; m_cnt = 0;
      end else begin
         if (stl && m_cnt < (1 << CW) - 1) m_cnt++;
         m_v = Flush ? 1'b0 : e_cap ? 1'b1 : issue ? 1'b0 : m_v;
      end
      if (WBEn) m_rf[WBAddr] = WBData;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      check_phase();
      advance();
   endtask

   initial begin
      idle();
      reset = 1;
      m_v = 0; m_cnt = 0; m_cso = 0; m_use = 0; m_rt = 0; m_pc = 0;
      for (int s = 0; s < 3; s++) m_src[s] = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;

      // Reset state
      check_phase();
      chk("rst_InReady", InReady, 1);
      chk("rst_CSOOut", CSOOut, 0);
      chk("rst_StallCount", StallCount, 0);
      advance();

      // Fill the register file
      for (int i = 0; i < 128; i++) begin
         WBEn = 1; WBAddr = 7'(i); WBData = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      idle();

      // RF write then read
      WBEn = 1; WBAddr = 5; WBData = {16{8'h11}};
      tick();
      idle();
      inst(6'b010000, 5, 0, 0, 3'b001, 10, 32'h100);
      tick();
      idle();
      check_phase();
      chk("rf_rd_Input1", Input1, {16{8'h11}});
      chk("rf_rd_ForwardA", ForwardA, 4'b0000);
      chk("rf_rd_Stalled", Stalled, 0);
      advance();

      // Permute producer at stage 5
      tg[5] = 8'h87; cs[5] = 6'b010000;
      inst(6'b010000, 0, 7, 0, 3'b010, 11, 32'h104);
      tick();
      InValid = 0;
      check_phase();
      chk("perm_ForwardB", ForwardB, 4'b0010);
      chk("perm_Stalled", Stalled, 0);
      advance();
      // Younger producer at stage 2 as well
      tg[2] = 8'h87;
      inst(6'b010000, 0, 7, 0, 3'b010, 12, 32'h108);
      tick();
      InValid = 0;
      check_phase();
      chk("perm2_Stalled", Stalled, 1);
      chk("perm2_CSOOut", CSOOut, 0);
      chk("perm2_InReady", InReady, 0);
      advance();
      idle();
      tick();

      // Load producer at stage 6 then stage 7
      tg[6] = 8'h89; cs[6] = 6'b110000;
      inst(6'b110000, 9, 0, 0, 3'b001, 13, 32'h10C);
      tick();
      InValid = 0;
      check_phase();
      chk("ld6_Stalled", Stalled, 1);
      advance();
      tg[6] = 0; tg[7] = 8'h89; cs[7] = 6'b110000;
      check_phase();
      chk("ld7_ForwardA", ForwardA, 4'b0100);
      chk("ld7_CSOOut", CSOOut, 6'b110000);
      advance();
      idle();

      // Write-through on RC
      inst(6'b100000, 0, 0, 3, 3'b100, 14, 32'h110);
      tick();
      idle();
      WBEn = 1; WBAddr = 3; WBData = 128'hABCD;
      check_phase();
      chk("wt_Input3", Input3, 128'hABCD);
      advance();
      idle();

      // Flush during a stall
      tg[1] = 8'h84; cs[1] = 6'b010000;
      inst(6'b010000, 4, 0, 0, 3'b001, 15, 32'h114);
      tick();
      InValid = 0;
      tick();
      tick();
      Flush = 1;
      InValid = 1;
      tick();
      Flush = 0; InValid = 0;
      check_phase();
      chk("flush_CSOOut", CSOOut, 0);
      chk("flush_InReady", InReady, 1);
      chk("flush_Stalled", Stalled, 0);
      advance();
      tick();
      idle();

      // Back-to-back throughput, then reset mid-stream
      for (int i = 0; i < 6; i++) begin
         inst(6'b010000, 7'(i), 7'(i + 1), 7'(i + 2), 3'b111, 7'(20 + i), 32'(i * 4));
         check_phase();
         if (i > 0) chk("thru_AddrOut", AddrOut, 7'(19 + i));
         advance();
      end
      reset = 1;
      tick();
      idle();
      check_phase();
      chk("rst2_CSOOut", CSOOut, 0);
      chk("rst2_StallCount", StallCount, 0);
      chk("rst2_InReady", InReady, 1);
      advance();

      // Stall-counter saturation
      tg[3] = 8'h82; cs[3] = 6'b010000;
      inst(6'b010000, 0, 2, 0, 3'b010, 30, 32'h200);
      tick();
      InValid = 0;
      for (int i = 0; i < 20; i++) tick();
      check_phase();
      chk("sat_StallCount", StallCount, 4'hF);
      advance();
      idle();
      reset = 1;
      tick();
      idle();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         inst(6'($urandom), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
              7'($urandom_range(0, 7)), 3'($urandom), 7'($urandom), $urandom);
         InValid = ($urandom_range(0, 3) != 0);
         Flush = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 63) == 0);
         WBEn = $urandom_range(0, 1);
         WBAddr = 7'($urandom_range(0, 9));
         WBData = {$urandom, $urandom, $urandom, $urandom};
         for (int k = 1; k <= 7; k++) begin
            tg[k] = {1'($urandom_range(0, 3) == 0), 7'($urandom_range(0, 7))};
            cs[k] = 6'($urandom);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
